sbus_output_arbiter: RTL and testbench
======================================

# sbus_output_arbiter

Round-robin arbiter that shares the single 16-bit sbus decoder output word between up to eight hardware requesters. It captures a winning requester's data word, presents it on out_port for a programmable hold time, and acknowledges the requester with a one-cycle grant pulse. An Avalon-MM slave port provides software control: enable mask, status and grant count. The block replaces a software-driven output register wherever several hardware sources need the decoder.

## Interface
- NUM_REQ, 4, number of requesters; legal range 2..8.
- DATA_W, 16, width of the data word and out_port.
- HOLD_CYCLES, 8, number of cycles each granted word is held valid; minimum 1.
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- req  in  NUM_REQ  request per requester; level, held until grant is seen.
- req_data  in  NUM_REQ*DATA_W  requester i data occupies bits [i*DATA_W +: DATA_W]; must be stable while req[i] is high.
- grant  out  NUM_REQ  one-hot, one-cycle pulse; data of requester i was captured.
- out_port  out  DATA_W  word driven to the sbus decoder.
- out_valid  out  1  high while out_port holds a freshly granted word.
- address  in  2  Avalon-MM register select.
- chipselect  in  1  Avalon-MM select.
- write_n  in  1  Avalon-MM write, active-low.
- writedata  in  32  Avalon-MM write data.
- readdata  out  32  Avalon-MM read data; combinational, zero wait states.

## Operation
- Registers:
  - Address 0, ENABLE: bits [NUM_REQ-1:0] mask requesters. R/W. Reset value is all ones.
  - Address 1, STATUS (RO):
    - bit0 busy (state HOLD).
    - bits[6:4] last_owner.
    - bit8 out_valid.
  - Address 2, GRANT_COUNT (bits[15:0]): saturates at 0xFFFF. Any write clears it to 0.
  - Address 3, OUT_WORD (RO): current out_port, zero-extended.
  - All unused readdata bits read 0. Writes to RO addresses are ignored.
- Eligibility: eligible = req & ENABLE.
- State machine has two states, IDLE and HOLD.
  - IDLE, eligible nonzero: select the winner by round-robin search from last_owner+1 modulo NUM_REQ, upward with wrap. At the clock edge:
    - out_port <= winner data.
    - grant[winner] <= 1.
    - out_valid <= 1.
    - last_owner <= winner.
    - hold counter <= HOLD_CYCLES-1.
    - GRANT_COUNT increments unless saturated.
    - State goes to HOLD.
  - IDLE, eligible zero: remain in IDLE; out_valid = 0.
  - HOLD, counter nonzero: decrement the counter. grant clears after its first cycle.
  - HOLD, counter zero: next edge goes to IDLE with out_valid <= 0.
  - HOLD always returns to IDLE. Requests are never evaluated in HOLD.
- out_port retains the last granted word after out_valid falls. It is only replaced by the next grant.
- Reset values:
  - out_port = 0, out_valid = 0, grant = 0.
  - state IDLE, last_owner = NUM_REQ-1, so requester 0 has first priority.
  - ENABLE = all ones, GRANT_COUNT = 0.
- ENABLE written during HOLD has no effect on the current hold. It applies to the next IDLE evaluation.
- Same-cycle GRANT_COUNT clear and grant: the clear wins and the count is 0.
- Requester deasserting req before grant: the request is withdrawn and no grant is issued.

## Timing
- Request to grant: req sampled high in IDLE at edge N gives grant and out_valid high in cycle N+1.
- out_valid stays high exactly HOLD_CYCLES cycles.
- Minimum spacing between grant pulses is HOLD_CYCLES+1 cycles, because of the mandatory IDLE cycle.
- That IDLE cycle lets a requester drop req after its grant before re-evaluation, including when HOLD_CYCLES = 1.
- readdata reflects registers in the same cycle as address. Register writes take effect at the next edge.
- Asynchronous reset mid-HOLD immediately clears grant, out_valid and out_port, and forces IDLE.

## Test plan
- Single request: HOLD_CYCLES = 8, req = 0001, data0 = 0xBEEF. Expected:
  - grant = 0001 for 1 cycle.
  - out_port = 0xBEEF.
  - out_valid high 8 cycles, then low.
  - GRANT_COUNT = 1.
- Round-robin: req = 1111 held continuously, each requester dropping req after its grant and re-raising 2 cycles later. Expected:
  - Grants in order 0, 1, 2, 3, 0.
  - Grant pulses spaced 9 cycles apart.
- Masking: write ENABLE = 0x5, then req = 1111. Expected:
  - Only requesters 0 and 2 are granted.
  - STATUS bits[6:4] alternate 0 and 2.
- Mid-hold mask and reset:
  - Clear ENABLE during HOLD: the current hold completes its full length.
  - Assert reset_n = 0 mid-HOLD: out_valid = 0 and out_port = 0 immediately; after release, requester 0 has priority.
- Counter: force 0xFFFF grants (or 0xFFFE plus 2 grants). Expected:
  - Count stays at 0xFFFF.
  - A write to address 2 in the same cycle as a grant reads 0 afterwards.
- HOLD_CYCLES = 1, req0 held high continuously. Expected:
  - Grants every 2 cycles.
  - out_valid pattern 1,0,1,0.

Source files
------------

// File: rtl/sbus_output_arbiter_if.sv
// rtl/sbus_output_arbiter_if.sv - requester, sbus output and register bus of the output arbiter
interface sbus_output_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        grant;
    logic [DATA_W-1:0]         out_port;
    logic                      out_valid;
    logic [1:0]                address;
    logic                      chipselect;
    logic                      write_n;
    logic [31:0]               writedata;
    logic [31:0]               readdata;

    modport slave (
        input  req, req_data, address, chipselect, write_n, writedata,
        output grant, out_port, out_valid, readdata
    );

    modport master (
        output req, req_data, address, chipselect, write_n, writedata,
        input  grant, out_port, out_valid, readdata
    );
endinterface

// File: rtl/sbus_output_arbiter.sv
// rtl/sbus_output_arbiter.sv - round-robin arbiter sharing the sbus decoder output word
module sbus_output_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 16,
    parameter int HOLD_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    sbus_output_arbiter_if.slave   bus
);
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t             state;
    logic [CNT_W-1:0]   hold_cnt;
    logic [2:0]         last_owner;
    logic [NUM_REQ-1:0] enable;
    logic [15:0]        grant_count;

    logic [7:0]         eligible;
    logic [3:0]         cand;
    logic [2:0]         winner;
    logic               win_found;
    logic [7:0]         win_onehot;
    logic               grant_fire;
    logic               reg_wr;

    // Round-robin search starting just after the previous owner, wrapping at NUM_REQ
    always_comb begin
        eligible                = '0;
        eligible[NUM_REQ-1:0]   = bus.req & enable;
        cand                    = '0;
        winner                  = last_owner;
        win_found               = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_owner} + 4'(k);
            if (cand >= 4'(NUM_REQ)) begin
                cand = cand - 4'(NUM_REQ);
            end
            if (!win_found && eligible[cand[2:0]]) begin
                winner    = cand[2:0];
                win_found = 1'b1;
            end
        end
    end

    assign win_onehot = 8'd1 << winner;
    assign grant_fire = (state == IDLE) && win_found;
    assign reg_wr     = bus.chipselect && !bus.write_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            hold_cnt     <= '0;
            last_owner   <= 3'(NUM_REQ - 1);
            bus.grant    <= '0;
            bus.out_port <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.grant <= '0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        bus.out_port  <= bus.req_data[int'(winner)*DATA_W +: DATA_W];
                        bus.grant     <= win_onehot[NUM_REQ-1:0];
                        bus.out_valid <= 1'b1;
                        last_owner    <= winner;
                        hold_cnt      <= CNT_W'(HOLD_CYCLES - 1);
                        state         <= HOLD;
                    end else begin
                        bus.out_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    // Always pass through IDLE so a granted requester can drop req first
                    if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - CNT_W'(1);
                    end else begin
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable      <= '1;
            grant_count <= '0;
        end else begin
            if (reg_wr && bus.address == 2'd0) begin
                enable <= bus.writedata[NUM_REQ-1:0];
            end
            // A clear landing on the same edge as a grant takes priority
            if (reg_wr && bus.address == 2'd2) begin
                grant_count <= '0;
            end else if (grant_fire && grant_count != 16'hFFFF) begin
                grant_count <= grant_count + 16'd1;
            end
        end
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            2'd0: bus.readdata[NUM_REQ-1:0] = enable;
            2'd1: begin
                bus.readdata[0]   = (state == HOLD);
                bus.readdata[6:4] = last_owner;
                bus.readdata[8]   = bus.out_valid;
            end
            2'd2: bus.readdata[15:0] = grant_count;
            2'd3: bus.readdata[DATA_W-1:0] = bus.out_port;
            default: bus.readdata = '0;
        endcase
    end
endmodule

// File: tb/tb_sbus_output_arbiter.sv
// tb/tb_sbus_output_arbiter.sv - directed table-driven bench for sbus_output_arbiter
module tb_sbus_output_arbiter;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    sbus_output_arbiter_if #(.NUM_REQ(4), .DATA_W(16)) b0 ();
    sbus_output_arbiter_if #(.NUM_REQ(4), .DATA_W(16)) b1 ();

    sbus_output_arbiter #(.NUM_REQ(4), .DATA_W(16), .HOLD_CYCLES(8)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b0.slave)
    );

    sbus_output_arbiter #(.NUM_REQ(4), .DATA_W(16), .HOLD_CYCLES(1)) u_dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b1.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  grant;
        logic        valid;
        logic [15:0] out;
    } vec_t;

    vec_t tab[10];
    vec_t tab1[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        b0.address    = a;
        b0.writedata  = d;
        b0.chipselect = 1'b1;
        b0.write_n    = 1'b0;
        @(negedge clk);
        b0.chipselect = 1'b0;
        b0.write_n    = 1'b1;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
        b0.address    = a;
        b0.chipselect = 1'b1;
        b0.write_n    = 1'b1;
        #1;
        d = b0.readdata;
        b0.chipselect = 1'b0;
    endtask

    task automatic wait_grant(input string name, input int maxc, output int idx);
        idx = -1;
        for (int c = 0; c < maxc; c++) begin
            @(negedge clk);
            if (b0.grant != 4'b0) begin
                for (int i = 0; i < 4; i++) if (b0.grant[i]) idx = i;
                break;
            end
        end
        if (idx < 0) begin
            checks++;
            errors++;
            $display("FAIL %s: no grant within %0d cycles", name, maxc);
        end
    endtask

    task automatic do_reset();
        b0.req = 4'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        int          idx;
        int          gidx[$];
        int          gcyc[$];
        int          raise_cnt[4];
        int          cyc;
        int          vcnt;
        int          extra;
        int          mask_exp[4];

        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        b0.req = '0; b0.req_data = '0; b0.address = '0; b0.chipselect = 1'b0;
        b0.write_n = 1'b1; b0.writedata = '0;
        b1.req = '0; b1.req_data = '0; b1.address = '0; b1.chipselect = 1'b0;
        b1.write_n = 1'b1; b1.writedata = '0;

        tab[0] = '{4'b0001, 4'b0001, 1'b1, 16'hBEEF};
        for (int i = 1; i < 8; i++) tab[i] = '{4'b0000, 4'b0000, 1'b1, 16'hBEEF};
        tab[8] = '{4'b0000, 4'b0000, 1'b0, 16'hBEEF};
        tab[9] = '{4'b0000, 4'b0000, 1'b0, 16'hBEEF};
        for (int i = 0; i < 6; i++)
            tab1[i] = '{4'b0001, (i % 2 == 0) ? 4'b0001 : 4'b0000, (i % 2 == 0), 16'h55AA};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset.grant", 32'(b0.grant), 32'h0);
        check("reset.out_valid", 32'(b0.out_valid), 32'h0);
        check("reset.out_port", 32'(b0.out_port), 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        reg_read(2'd0, rd); check("reset.enable", rd, 32'hF);
        reg_read(2'd1, rd); check("reset.status", rd, 32'h30);
        reg_read(2'd2, rd); check("reset.count", rd, 32'h0);

        // Single request
        b0.req_data[15:0] = 16'hBEEF;
        for (int i = 0; i < 10; i++) begin
            b0.req = tab[i].req;
            @(negedge clk);
            check($sformatf("single[%0d].grant", i), 32'(b0.grant), 32'(tab[i].grant));
            check($sformatf("single[%0d].valid", i), 32'(b0.out_valid), 32'(tab[i].valid));
            check($sformatf("single[%0d].out", i), 32'(b0.out_port), 32'(tab[i].out));
        end
        reg_read(2'd2, rd); check("single.count", rd, 32'h1);
        reg_read(2'd3, rd); check("single.out_word", rd, 32'hBEEF);

        // Round-robin with requesters dropping and re-raising
        do_reset();
        for (int i = 0; i < 4; i++) begin
            b0.req_data[i*16 +: 16] = 16'hA000 + 16'(i);
            raise_cnt[i] = 0;
        end
        b0.req = 4'hF;
        cyc = 0;
        while (gidx.size() < 5 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 4; i++) begin
                if (raise_cnt[i] > 0) begin
                    raise_cnt[i]--;
                    if (raise_cnt[i] == 0) b0.req[i] = 1'b1;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (b0.grant[i]) begin
                    gidx.push_back(i);
                    gcyc.push_back(cyc);
                    check($sformatf("rr.data%0d", gidx.size()), 32'(b0.out_port), 32'hA000 + 32'(i));
                    b0.req[i] = 1'b0;
                    raise_cnt[i] = 2;
                end
            end
        end
        check("rr.num_grants", 32'(gidx.size()), 32'd5);
        for (int i = 0; i < gidx.size(); i++) begin
            check($sformatf("rr.order%0d", i), 32'(gidx[i]), 32'(i % 4));
            if (i > 0) check($sformatf("rr.spacing%0d", i), 32'(gcyc[i] - gcyc[i-1]), 32'd9);
        end

        // Masking
        do_reset();
        reg_write(2'd0, 32'h5);
        b0.req = 4'hF;
        mask_exp = '{0, 2, 0, 2};
        for (int g = 0; g < 4; g++) begin
            wait_grant($sformatf("mask.wait%0d", g), 30, idx);
            if (idx >= 0) begin
                check($sformatf("mask.grant%0d", g), 32'(idx), 32'(mask_exp[g]));
                reg_read(2'd1, rd);
                check($sformatf("mask.last_owner%0d", g), 32'(rd[6:4]), 32'(mask_exp[g]));
                check($sformatf("mask.busy%0d", g), 32'(rd[0]), 32'h1);
            end
        end

        // Clearing ENABLE mid-hold lets the current hold finish
        do_reset();
        b0.req = 4'b0001;
        wait_grant("midmask.wait", 30, idx);
        vcnt = 1;
        extra = 0;
        reg_write(2'd0, 32'h0);
        if (b0.out_valid) vcnt++;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (b0.out_valid) vcnt++;
            if (b0.grant != 4'b0) extra++;
        end
        check("midmask.valid_cycles", 32'(vcnt), 32'd8);
        check("midmask.no_regrant", 32'(extra), 32'd0);
        reg_read(2'd2, rd); check("midmask.count", rd, 32'h1);

        // Asynchronous reset mid-hold, then requester 0 first
        reg_write(2'd0, 32'hF);
        wait_grant("midreset.wait", 30, idx);
        repeat (3) @(negedge clk);
        check("midreset.pre_valid", 32'(b0.out_valid), 32'h1);
        reset_n = 1'b0;
        #1;
        check("midreset.valid", 32'(b0.out_valid), 32'h0);
        check("midreset.out_port", 32'(b0.out_port), 32'h0);
        check("midreset.grant", 32'(b0.grant), 32'h0);
        reg_read(2'd1, rd); check("midreset.status", rd, 32'h30);
        @(negedge clk);
        reset_n = 1'b1;
        b0.req = 4'hF;
        wait_grant("midreset.after", 30, idx);
        check("midreset.first_owner", 32'(idx), 32'd0);

        // Grant counter saturation and same-cycle clear
        do_reset();
        force u_dut.grant_count = 16'hFFFE;
        #1;
        release u_dut.grant_count;
        b0.req = 4'b0001;
        wait_grant("count.wait1", 30, idx);
        reg_read(2'd2, rd); check("count.ffff", rd, 32'hFFFF);
        wait_grant("count.wait2", 30, idx);
        reg_read(2'd2, rd); check("count.saturate", rd, 32'hFFFF);
        repeat (8) @(negedge clk);
        reg_write(2'd2, 32'h0);
        check("count.clear_grant", 32'(b0.grant), 32'h1);
        reg_read(2'd2, rd); check("count.clear_wins", rd, 32'h0);

        // HOLD_CYCLES = 1 instance
        b1.req_data[15:0] = 16'h55AA;
        for (int i = 0; i < 6; i++) begin
            b1.req = tab1[i].req;
            @(negedge clk);
            check($sformatf("hold1[%0d].grant", i), 32'(b1.grant), 32'(tab1[i].grant));
            check($sformatf("hold1[%0d].valid", i), 32'(b1.out_valid), 32'(tab1[i].valid));
            check($sformatf("hold1[%0d].out", i), 32'(b1.out_port), 32'(tab1[i].out));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
